// File: rtl/wb_timer_irq.sv
// Wishbone-slave compare timer: prescaled up-counter, compare register,
// sticky match flag and a level interrupt (MATCH & IRQ_EN).
module wb_timer_irq #(
    parameter int PRESC_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_err_o,
    output logic        irq_o
);
    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_PRESC = 3'd1;
    localparam logic [2:0] A_CMP   = 3'd2;
    localparam logic [2:0] A_CNT   = 3'd3;
    localparam logic [2:0] A_STAT  = 3'd4;

    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]   cmp_q, cmp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic [31:0]        rdata, wr_val;
    logic [2:0]         reg_sel;
    logic               req, wr_en, tick;
    logic               unused_adr;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    assign reg_sel    = wb_adr_i[4:2];
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
    assign req        = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en      = req & wb_we_i;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            A_CTRL:  rdata[2:0]         = ctrl_q;
            A_PRESC: rdata[PRESC_W-1:0] = presc_q;
            A_CMP:   rdata[CNT_W-1:0]   = cmp_q;
            A_CNT:   rdata[CNT_W-1:0]   = cnt_q;
            A_STAT:  rdata[0]           = match_q;
            default: rdata = '0;
        endcase
    end

    // Partial writes merge into the addressed register's current value.
    assign wr_val = byte_merge(rdata, wb_dat_i, wb_sel_i);

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        pc_d    = pc_q;
        tick    = 1'b0;
        ack_d   = req;
        dat_d   = req ? rdata : dat_q;

        if (!ctrl_q[0]) begin
            pc_d = '0;
        end else if (pc_q == presc_q) begin
            pc_d = '0;
            tick = 1'b1;
        end else begin
            pc_d = pc_q + PRESC_W'(1);
        end

        // W1C is applied before the tick so a same-edge match is not lost.
        if (wr_en && reg_sel == A_STAT && wb_sel_i[0] && wb_dat_i[0])
            match_d = 1'b0;

        if (tick) begin
            if (cnt_q == cmp_q) begin
                match_d = 1'b1;
                if (ctrl_q[1]) cnt_d = '0;
                else           ctrl_d[0] = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Bus writes come last so they override the tick's CNT/EN updates.
        if (wr_en) begin
            case (reg_sel)
                A_CTRL: begin
                    ctrl_d = wr_val[2:0];
                    pc_d   = '0;
                end
                A_PRESC: begin
                    presc_d = wr_val[PRESC_W-1:0];
                    pc_d    = '0;
                end
                A_CMP:   cmp_d = wr_val[CNT_W-1:0];
                A_CNT:   cnt_d = wr_val[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            pc_q    <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign wb_stall_o = 1'b0;
    assign wb_err_o   = 1'b0;
    assign irq_o      = match_q & ctrl_q[2];

endmodule

// File: tb/tb_wb_timer_irq.sv
// Scenario bench for wb_timer_irq: register access, periodic and one-shot
// matching, W1C race, counter wrap, byte enables and bus handshake.
module tb_wb_timer_irq;
    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [31:0] adr, dat_i, dat_o;
    logic [3:0]  sel;
    logic        ack, stall, err, irq;

    int          checks = 0;
    int          failures = 0;
    int          cyc_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_timer_irq dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_stall_o(stall), .wb_err_o(err),
        .irq_o(irq)
    );

    task automatic bus_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, a, 2'b00}; dat_i = d; sel = s;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 8);
        if (!ack) begin
            checks++; failures++;
            $display("FAIL bus_timeout adr=%0d got_ack=0 need_ack=1", a);
        end
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        bus_xfer(1'b1, a, d, s, rd, lat);
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] rd);
        int lat;
        bus_xfer(1'b0, a, 32'd0, 4'hF, rd, lat);
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!irq && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd, e;
        int lat;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b need=0", irq); end
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back(32'd0);
            bus_xfer(1'b0, a[2:0], 32'd0, 4'hF, rd, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin failures++; $display("FAIL reset_reg%0d got=%h need=%h", a, rd, e); end
            checks++;
            if (lat !== 1) begin failures++; $display("FAIL ack_latency got=%0d need=1", lat); end
            @(posedge clk); #1;
            checks++;
            if (ack !== 1'b0) begin failures++; $display("FAIL ack_one_cycle got=%b need=0", ack); end
        end
    endtask

    task automatic test_reserved();
        logic [31:0] rd, e;
        wr(3'd5, 32'hFFFF_FFFF, 4'hF);
        wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        exp_q.push_back(32'd0); rd_reg(3'd5, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL reserved5 got=%h need=%h", rd, e); end
        exp_q.push_back(32'd0); rd_reg(3'd7, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL reserved7 got=%h need=%h", rd, e); end
    endtask

    task automatic test_periodic();
        logic [31:0] rd, e;
        int n, t1, t2;
        wr(3'd0, 32'd0, 4'hF); wr(3'd4, 32'd1, 4'hF); wr(3'd3, 32'd0, 4'hF);
        wr(3'd1, 32'd3, 4'hF); wr(3'd2, 32'd5, 4'hF);
        wr(3'd0, 32'h7, 4'hF);
        wait_irq(n);
        t1 = cyc_cnt;
        checks++;
        if (n !== 24) begin failures++; $display("FAIL periodic_first got=%0d need=24", n); end
        exp_q.push_back(32'd0); rd_reg(3'd3, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL periodic_cnt_reload got=%h need=%h", rd, e); end
        wr(3'd4, 32'd1, 4'hF);
        wait_irq(n);
        t2 = cyc_cnt;
        checks++;
        if (t2 - t1 !== 24) begin failures++; $display("FAIL periodic_period got=%0d need=24", t2 - t1); end
        wr(3'd0, 32'd0, 4'hF);
        wr(3'd4, 32'd1, 4'hF);
    endtask

    task automatic test_one_shot();
        logic [31:0] rd, e;
        int n;
        wr(3'd1, 32'd0, 4'hF); wr(3'd2, 32'd2, 4'hF); wr(3'd3, 32'd0, 4'hF);
        wr(3'd0, 32'h5, 4'hF);
        wait_irq(n);
        checks++;
        if (n !== 3) begin failures++; $display("FAIL oneshot_ticks got=%0d need=3", n); end
        exp_q.push_back(32'h4); rd_reg(3'd0, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL oneshot_ctrl got=%h need=%h", rd, e); end
        exp_q.push_back(32'h2); rd_reg(3'd3, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL oneshot_cnt got=%h need=%h", rd, e); end
        exp_q.push_back(32'h1); rd_reg(3'd4, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL oneshot_status got=%h need=%h", rd, e); end
        wr(3'd0, 32'd0, 4'hF);
        wr(3'd4, 32'd1, 4'hF);
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd, e;
        wr(3'd1, 32'd0, 4'hF); wr(3'd2, 32'd3, 4'hF); wr(3'd3, 32'd0, 4'hF);
        wr(3'd0, 32'h7, 4'hF);
        // The W1C below is accepted on the fourth edge, the same edge as the match.
        repeat (2) @(posedge clk);
        wr(3'd4, 32'd1, 4'hF);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL w1c_race_irq got=%b need=1", irq); end
        wr(3'd0, 32'h4, 4'hF);
        exp_q.push_back(32'h1); rd_reg(3'd4, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL w1c_race_status got=%h need=%h", rd, e); end
        wr(3'd4, 32'd1, 4'hF);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL w1c_clear_irq got=%b need=0", irq); end
        exp_q.push_back(32'h0); rd_reg(3'd4, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL w1c_clear_status got=%h need=%h", rd, e); end
        wr(3'd0, 32'd0, 4'hF);
    endtask

    task automatic test_wrap();
        logic [31:0] rd, e;
        wr(3'd1, 32'd0, 4'hF); wr(3'd2, 32'd1, 4'hF); wr(3'd3, 32'hFFFF_FFFF, 4'hF);
        wr(3'd0, 32'h5, 4'hF);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (irq !== (i == 3)) begin
                failures++; $display("FAIL wrap_irq_tick%0d got=%b need=%b", i, irq, (i == 3));
            end
        end
        exp_q.push_back(32'h1); rd_reg(3'd3, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL wrap_cnt got=%h need=%h", rd, e); end
        wr(3'd0, 32'd0, 4'hF);
        wr(3'd4, 32'd1, 4'hF);
    endtask

    task automatic test_cnt_write();
        logic [31:0] rd, e;
        wr(3'd1, 32'd0, 4'hF); wr(3'd2, 32'hFFFF, 4'hF); wr(3'd3, 32'd0, 4'hF);
        wr(3'd0, 32'h1, 4'hF);
        wr(3'd3, 32'd100, 4'hF);
        exp_q.push_back(32'd101); rd_reg(3'd3, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL cnt_write_priority got=%h need=%h", rd, e); end
        wr(3'd0, 32'd0, 4'hF);
    endtask

    task automatic test_byte_write();
        logic [31:0] rd, e;
        wr(3'd2, 32'd0, 4'hF);
        wr(3'd2, 32'h0000_AB00, 4'b0010);
        exp_q.push_back(32'h0000_AB00); rd_reg(3'd2, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL byte_write_b1 got=%h need=%h", rd, e); end
        wr(3'd2, 32'hDEAD_BEEF, 4'b1001);
        exp_q.push_back(32'hDE00_ABEF); rd_reg(3'd2, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL byte_write_b30 got=%h need=%h", rd, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        wr(3'd1, 32'h1234, 4'hF);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_q.push_back(32'h1234);
            @(posedge clk); #1;
            checks++;
            if (ack !== (i % 2 == 0)) begin
                failures++; $display("FAIL b2b_ack%0d got=%b need=%b", i, ack, (i % 2 == 0));
            end
            if (ack) begin
                e = exp_q.pop_front();
                checks++;
                if (dat_o !== e) begin failures++; $display("FAIL b2b_data%0d got=%h need=%h", i, dat_o, e); end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, e;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; dat_i = 32'h55; sel = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL reset_mid_ack got=%b need=0", ack); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(32'd0); rd_reg(3'd2, rd); e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin failures++; $display("FAIL reset_mid_cmp got=%h need=%h", rd, e); end
    endtask

    initial begin
        test_reset();
        test_reserved();
        test_periodic();
        test_one_shot();
        test_w1c_race();
        test_wrap();
        test_cnt_write();
        test_byte_write();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
